// File: rtl/seq_divider_hs.sv
// Multi-cycle restoring integer divider with valid/ready handshakes on both sides.
// Signed/unsigned per transaction; fixed latency of WIDTH+1 cycles from accept to out_valid.
module seq_divider_hs #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_zero,
  output logic             out_overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH:0]   dvs;
  logic [WIDTH-1:0] a_orig;
  logic             neg_q, neg_r, dz, ov;

  // Operand magnitudes at accept time, WIDTH+1 bits so MIN negates exactly
  logic             sgn, a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  assign sgn   = SIGNED_EN & in_signed;
  assign a_neg = sgn & in_dividend[WIDTH-1];
  assign b_neg = sgn & in_divisor[WIDTH-1];
  assign a_ext = {a_neg, in_dividend};
  assign b_ext = {b_neg, in_divisor};
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  // One restoring step: shift in next dividend bit, subtract if it fits
  logic [WIDTH:0] shifted, diff;
  logic           fits;
  assign shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};
  assign diff    = shifted - dvs;
  assign fits    = (shifted >= dvs);

  logic [WIDTH-1:0] q_fix, r_fix;
  assign q_fix = neg_q ? -dq : dq;
  assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_overflow  <= 1'b0;
      cnt           <= '0;
      rem           <= '0;
      dq            <= '0;
      dvs           <= '0;
      a_orig        <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz            <= 1'b0;
      ov            <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Top magnitude bit seeds the partial remainder (always 0, keeps full width)
          rem      <= {{WIDTH{1'b0}}, a_mag[WIDTH]};
          dq       <= a_mag[WIDTH-1:0];
          dvs      <= b_mag;
          a_orig   <= in_dividend;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          dz       <= (in_divisor == '0);
          ov       <= sgn && (in_dividend == MIN_V) && (in_divisor == ONES_V);
          cnt      <= CW'(WIDTH);
          in_ready <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          rem <= fits ? diff : shifted;
          dq  <= {dq[WIDTH-2:0], fits};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (dz) begin
            out_quotient  <= ONES_V;
            out_remainder <= a_orig;
          end else if (ov) begin
            out_quotient  <= MIN_V;
            out_remainder <= '0;
          end else begin
            out_quotient  <= q_fix;
            out_remainder <= r_fix;
          end
          out_div_zero <= dz;
          out_overflow <= ov && !dz;
          out_valid    <= 1'b1;
          state        <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid    <= 1'b0;
          out_div_zero <= 1'b0;
          out_overflow <= 1'b0;
          in_ready     <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_hs.sv
// Directed bench for seq_divider_hs (WIDTH=8, SIGNED_EN=1) with hand-computed results.
module tb_seq_divider_hs;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_signed;
  logic [7:0] in_dividend, in_divisor;
  logic       out_valid, out_ready;
  logic [7:0] out_quotient, out_remainder;
  logic       out_div_zero, out_overflow;

  int checks = 0;
  int errors = 0;
  int lat;

  seq_divider_hs #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_zero(out_div_zero), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, accept it, scramble inputs, count edges until out_valid
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s, output int n);
    @(negedge clk);
    chk("in_ready_before_req", int'(in_ready), 1);
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0; in_dividend = 8'hA5; in_divisor = 8'h3C; in_signed = ~s;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic result(input string tag, input int n, input logic [7:0] q, input logic [7:0] r,
                        input logic dz, input logic ov);
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_q"}, int'(out_quotient), int'(q));
    chk({tag, "_r"}, int'(out_remainder), int'(r));
    chk({tag, "_dz"}, int'(out_div_zero), int'(dz));
    chk({tag, "_ov"}, int'(out_overflow), int'(ov));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = '0; in_divisor = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_q", int'(out_quotient), 0);
    chk("rst_r", int'(out_remainder), 0);
    chk("rst_dz", int'(out_div_zero), 0);
    chk("rst_ov", int'(out_overflow), 0);
    rst_n = 1'b1;

    run(8'd100, 8'd7, 1'b0, lat);   result("u100_7", lat, 8'd14, 8'd2, 0, 0);   consume("u100_7");
    run(8'hF9, 8'h02, 1'b1, lat);   result("s_m7_2", lat, 8'hFD, 8'hFF, 0, 0); consume("s_m7_2");
    run(8'h07, 8'hFE, 1'b1, lat);   result("s_7_m2", lat, 8'hFD, 8'h01, 0, 0); consume("s_7_m2");
    run(8'h5A, 8'h00, 1'b0, lat);   result("u_dz", lat, 8'hFF, 8'h5A, 1, 0);   consume("u_dz");
    run(8'h5A, 8'h00, 1'b1, lat);   result("s_dz", lat, 8'hFF, 8'h5A, 1, 0);   consume("s_dz");
    run(8'h80, 8'hFF, 1'b1, lat);   result("s_ovf", lat, 8'h80, 8'h00, 0, 1);  consume("s_ovf");
    run(8'h80, 8'hFF, 1'b0, lat);   result("u_80_ff", lat, 8'h00, 8'h80, 0, 0); consume("u_80_ff");
    // -128/7: magnitude 128/7 = 18 r 2 -> q=-18, r=-2
    run(8'h80, 8'h07, 1'b1, lat);   result("s_min_7", lat, 8'hEE, 8'hFE, 0, 0);

    // Backpressure on the previous result: hold out_ready low for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_q", int'(out_quotient), 8'hEE);
      chk("bp_r", int'(out_remainder), 8'hFE);
    end
    consume("bp");
    run(8'd200, 8'd9, 1'b0, lat);   result("u200_9", lat, 8'd22, 8'd2, 0, 0);  consume("u200_9");

    // Abort mid-computation: reset during the 4th iteration
    @(negedge clk);
    in_valid = 1'b1; in_dividend = 8'd77; in_divisor = 8'd5; in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run(8'd255, 8'd16, 1'b0, lat);  result("u255_16", lat, 8'd15, 8'd15, 0, 0); consume("u255_16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
